// File: rtl/accel_pkg.sv
// ============================================================================
// accel_pkg : shared types and constants for the pool sequencer  (rev 1.0)
// ============================================================================
`default_nettype none

package accel_pkg;

    localparam int COORD_W_DEFAULT = 4;

    localparam logic [1:0] Q_TL = 2'd0;
    localparam logic [1:0] Q_TR = 2'd1;
    localparam logic [1:0] Q_BL = 2'd2;
    localparam logic [1:0] Q_BR = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        POOL = 3'd3,
        OUT  = 3'd4,
        DONE = 3'd5
    } seq_state_t;

    // Row/column offset of a quadrant inside its 2x2 pooling window.
    function automatic logic quad_row(input logic [1:0] q);
        return (q == Q_BL) || (q == Q_BR);
    endfunction

    function automatic logic quad_col(input logic [1:0] q);
        return (q == Q_TR) || (q == Q_BR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/window_counter.sv
// ============================================================================
// window_counter : pooling-window row/col and quadrant counters  (rev 1.0)
// ============================================================================
`default_nettype none

module window_counter
    import accel_pkg::*;
#(
    parameter int MAP_W   = 8,
    parameter int MAP_H   = 8,
    parameter int COORD_W = COORD_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               inc_q_i,
    input  logic               inc_win_i,
    output logic [COORD_W-1:0] r_o,
    output logic [COORD_W-1:0] c_o,
    output logic [1:0]         q_o,
    output logic               last_q_o,
    output logic               last_win_o
);

    localparam logic [COORD_W-1:0] C_LAST = COORD_W'(MAP_W / 2 - 1);
    localparam logic [COORD_W-1:0] R_LAST = COORD_W'(MAP_H / 2 - 1);

    logic [COORD_W-1:0] r_q, r_d;
    logic [COORD_W-1:0] c_q, c_d;
    logic [1:0]         q_q, q_d;

    always_comb begin
        r_d = r_q;
        c_d = c_q;
        q_d = q_q;
        if (clear_i) begin
            r_d = '0;
            c_d = '0;
            q_d = Q_TL;
        end else if (inc_win_i) begin
            q_d = Q_TL;
            if (c_q == C_LAST) begin
                c_d = '0;
                r_d = (r_q == R_LAST) ? '0 : r_q + 1'b1;
            end else begin
                c_d = c_q + 1'b1;
            end
        end else if (inc_q_i) begin
            q_d = q_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
            c_q <= '0;
            q_q <= Q_TL;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
            q_q <= q_d;
        end
    end

    assign r_o        = r_q;
    assign c_o        = c_q;
    assign q_o        = q_q;
    assign last_q_o   = (q_q == Q_BR);
    assign last_win_o = (c_q == C_LAST) && (r_q == R_LAST);

endmodule

`default_nettype wire

// File: rtl/pool_sequencer.sv
// ============================================================================
// pool_sequencer : sequences conv requests and 2x2 pooling over one map (rev 1.0)
// ============================================================================
`default_nettype none

module pool_sequencer
    import accel_pkg::*;
#(
    parameter int MAP_W   = 8,
    parameter int MAP_H   = 8,
    parameter int COORD_W = COORD_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               conv_req,
    output logic [COORD_W-1:0] conv_row,
    output logic [COORD_W-1:0] conv_col,
    input  logic               conv_valid,
    output logic               pool_acc,
    output logic [1:0]         pool_idx,
    output logic               pool_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_row,
    output logic [COORD_W-1:0] out_col
);

    if ((MAP_W % 2) != 0 || MAP_W < 2) begin : g_bad_map_w
        $error("pool_sequencer: MAP_W must be even and >= 2");
    end
    if ((MAP_H % 2) != 0 || MAP_H < 2) begin : g_bad_map_h
        $error("pool_sequencer: MAP_H must be even and >= 2");
    end
    if ((1 << COORD_W) < MAP_W || (1 << COORD_W) < MAP_H) begin : g_bad_coord_w
        $error("pool_sequencer: COORD_W too narrow for the map size");
    end

    seq_state_t         state_q, state_d;
    logic               ctr_clear, ctr_inc_q, ctr_inc_win;
    logic [COORD_W-1:0] win_r, win_c;
    logic [1:0]         win_q;
    logic               last_q, last_win;
    logic               busy_q, done_q, conv_req_q, pool_en_q, out_valid_q;
    logic [COORD_W-1:0] px_row, px_col;

    window_counter #(
        .MAP_W   (MAP_W),
        .MAP_H   (MAP_H),
        .COORD_W (COORD_W)
    ) u_window_counter (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (ctr_clear),
        .inc_q_i    (ctr_inc_q),
        .inc_win_i  (ctr_inc_win),
        .r_o        (win_r),
        .c_o        (win_c),
        .q_o        (win_q),
        .last_q_o   (last_q),
        .last_win_o (last_win)
    );

    // abort overrides every transition, including a same-cycle handshake.
    always_comb begin
        state_d     = state_q;
        ctr_clear   = 1'b0;
        ctr_inc_q   = 1'b0;
        ctr_inc_win = 1'b0;
        if (abort && state_q != IDLE) begin
            state_d   = IDLE;
            ctr_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d   = REQ;
                    ctr_clear = 1'b1;
                end
                REQ:  state_d = WAIT;
                WAIT: if (conv_valid) begin
                    if (last_q) begin
                        state_d = POOL;
                    end else begin
                        state_d   = REQ;
                        ctr_inc_q = 1'b1;
                    end
                end
                POOL: state_d = OUT;
                OUT:  if (out_ready) begin
                    ctr_inc_win = 1'b1;
                    state_d     = last_win ? DONE : REQ;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Strobes are registered from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            conv_req_q  <= 1'b0;
            pool_en_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
            conv_req_q  <= (state_d == REQ);
            pool_en_q   <= (state_d == POOL);
            out_valid_q <= (state_d == OUT);
        end
    end

    assign px_row = (win_r << 1) | {{(COORD_W-1){1'b0}}, quad_row(win_q)};
    assign px_col = (win_c << 1) | {{(COORD_W-1){1'b0}}, quad_col(win_q)};

    assign busy      = busy_q;
    assign done      = done_q;
    assign conv_req  = conv_req_q;
    assign conv_row  = conv_req_q ? px_row : '0;
    assign conv_col  = conv_req_q ? px_col : '0;
    assign pool_acc  = conv_valid & (state_q == WAIT);
    assign pool_idx  = win_q;
    assign pool_en   = pool_en_q;
    assign out_valid = out_valid_q;
    assign out_row   = out_valid_q ? win_r : '0;
    assign out_col   = out_valid_q ? win_c : '0;

endmodule

`default_nettype wire

// File: tb/tb_pool_sequencer.sv
// ============================================================================
// tb_pool_sequencer : randomized bench with event-level reference model (rev 1.0)
// ============================================================================
`default_nettype none

module tb_pool_sequencer;

    localparam int MW   = 4;
    localparam int MH   = 4;
    localparam int CW   = 4;
    localparam int NWIN = (MW / 2) * (MH / 2);

    logic          clk = 1'b0;
    logic          rst, start, abort, conv_valid, out_ready;
    logic          busy, done, conv_req, pool_acc, pool_en, out_valid;
    logic [CW-1:0] conv_row, conv_col, out_row, out_col;
    logic [1:0]    pool_idx;

    int checks   = 0;
    int failures = 0;

    pool_sequencer #(.MAP_W(MW), .MAP_H(MH), .COORD_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .conv_req   (conv_req),
        .conv_row   (conv_row),
        .conv_col   (conv_col),
        .conv_valid (conv_valid),
        .pool_acc   (pool_acc),
        .pool_idx   (pool_idx),
        .pool_en    (pool_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .out_col    (out_col)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference ordering: window-major, quadrant-minor, rows of windows.
    function automatic int exp_crow(input int k);
        int w = k / 4;
        return 2 * (w / (MW / 2)) + (k % 4) / 2;
    endfunction

    function automatic int exp_ccol(input int k);
        int w = k / 4;
        return 2 * (w % (MW / 2)) + (k % 4) % 2;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_conv_req"},  conv_req,  0);
        chk({tag, "_conv_row"},  conv_row,  0);
        chk({tag, "_conv_col"},  conv_col,  0);
        chk({tag, "_pool_acc"},  pool_acc,  0);
        chk({tag, "_pool_idx"},  pool_idx,  0);
        chk({tag, "_pool_en"},   pool_en,   0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_row"},   out_row,   0);
        chk({tag, "_out_col"},   out_col,   0);
    endtask

    // dmode: 0 none, 1 extra 4 on third request, 2 random extra wait.
    // rmode: 0 always ready, 1 stall 3 at first OUT, 2 random ready.
    task automatic run_pass(input int dmode, input int rmode, input bit spur,
                            input int abort_req, input bit rst_out, input bit chk_t);
        int reqs = 0, resps = 0, outs = 0, cnt = 0, extra = 0, stall = 0;
        int cyc = 0, post = -1, acc_idx = 0;
        bit awaiting = 0, was_wait, e_req, e_pool = 0, e_done = 0, out_ph = 0;
        bit active = 1, e_acc, first_pool = 1, ended = 0, rdy;
        bit n_req, n_pool, n_done, n_out;

        @(negedge clk);
        start = 1'b1; abort = 1'b0; conv_valid = 1'b0; out_ready = 1'b0;
        e_req = 1'b1;
        for (int i = 0; i < 3000 && !ended; i++) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            chk("busy",      busy,      active);
            chk("conv_req",  conv_req,  e_req);
            chk("pool_en",   pool_en,   e_pool);
            chk("out_valid", out_valid, out_ph);
            chk("done",      done,      e_done);
            if (e_req) begin
                chk("conv_row", conv_row, exp_crow(reqs));
                chk("conv_col", conv_col, exp_ccol(reqs));
            end
            if (out_ph) begin
                chk("out_row", out_row, outs / (MW / 2));
                chk("out_col", out_col, outs % (MW / 2));
            end
            if (e_pool && first_pool) begin
                if (chk_t) chk("pool_en_time", cyc, 9 + extra);
                first_pool = 0;
            end
            if (e_done && chk_t) chk("done_time", cyc, 41 + extra);

            if (rst_out && out_ph && outs == 0) begin
                conv_valid = 1'b0;
                out_ready  = 1'b0;
                #2 rst = 1'b1;
                #1 chk_all_zero("async_rst");
                @(negedge clk);
                rst   = 1'b0;
                ended = 1;
            end else begin
                n_req = 0; n_pool = 0; n_done = 0; n_out = out_ph; e_acc = 0;
                conv_valid = 1'b0;
                out_ready  = 1'b0;
                was_wait   = awaiting && !e_req;
                if (e_req) begin
                    awaiting = 1;
                    cnt = (dmode == 1) ? ((reqs == 2) ? 4 : 0)
                        : (dmode == 2) ? $urandom_range(0, 3) : 0;
                    reqs++;
                    if (spur) conv_valid = 1'($urandom_range(0, 1));
                end else if (awaiting) begin
                    if (cnt == 0) begin
                        conv_valid = 1'b1;
                        e_acc      = 1;
                        acc_idx    = resps;
                        awaiting   = 0;
                        resps++;
                        if (resps % 4 == 0) n_pool = 1;
                        else                n_req  = 1;
                    end else begin
                        cnt--;
                        extra++;
                    end
                end else if (spur) begin
                    conv_valid = 1'($urandom_range(0, 1));
                end
                if (e_pool) n_out = 1;
                if (out_ph) begin
                    rdy = (rmode == 0) ? 1'b1
                        : (rmode == 1) ? !(outs == 0 && stall < 3)
                        : ($urandom_range(0, 3) != 0);
                    if (!rdy) begin
                        stall++;
                        extra++;
                    end else begin
                        out_ready = 1'b1;
                        n_out     = 0;
                        outs++;
                        if (outs == NWIN) n_done = 1;
                        else              n_req  = 1;
                    end
                end
                if (spur && active) start = 1'($urandom_range(0, 1));
                if (e_done) begin
                    active = 0;
                    post   = 3;
                end
                if (abort_req >= 0 && was_wait && (reqs - 1) == abort_req) begin
                    abort    = 1'b1;
                    active   = 0;
                    awaiting = 0;
                    n_req = 0; n_pool = 0; n_done = 0; n_out = 0;
                    post  = 4;
                end
                #1;
                chk("pool_acc", pool_acc, e_acc);
                if (e_acc) chk("pool_idx", pool_idx, acc_idx % 4);
                e_req  = n_req;
                e_pool = n_pool;
                e_done = n_done;
                out_ph = n_out;
                if (post == 0)     ended = 1;
                else if (post > 0) post--;
            end
        end
        if (!ended) chk("timeout", 0, 1);
        conv_valid = 1'b0;
        out_ready  = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; conv_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        run_pass(0, 0, 0, -1, 0, 1);   // best case timing
        run_pass(1, 0, 0, -1, 0, 1);   // delayed third result
        run_pass(0, 1, 0, -1, 0, 1);   // output stall
        run_pass(0, 0, 1, -1, 0, 1);   // spurious conv_valid / start
        run_pass(0, 0, 0,  5, 0, 0);   // abort in window 2 wait
        run_pass(0, 0, 0, -1, 0, 1);   // restart from origin
        run_pass(0, 0, 0, -1, 1, 0);   // async reset during first OUT
        run_pass(0, 0, 0, -1, 0, 1);
        for (int k = 0; k < 6; k++) run_pass(2, 2, 1, -1, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
